// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types, defaults and reset pattern for the scoreboarded register file
package regfile_pkg;

  localparam int XLEN_DEFAULT  = 64;
  localparam int NREGS_DEFAULT = 32;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] xlen_t;

  // mode 1 is the lab pattern (reg i holds i+1); register 0 is always zero
  function automatic xlen_t init_value(input int i, input int mode);
    if (mode == 1 && i != 0) begin
      return xlen_t'(i + 1);
    end
    return '0;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - decode/write-back bus of the scoreboarded register file
interface regfile_scoreboard_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
);
  localparam int AW = $clog2(NREGS);

  logic             rd_req;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [XLEN-1:0]  rdata1;
  logic [XLEN-1:0]  rdata2;
  logic             rvalid;
  logic             rbusy1;
  logic             rbusy2;
  logic             iss_en;
  logic [AW-1:0]    iss_rd;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [XLEN-1:0]  wb_data;
  logic [NREGS-1:0] busy_vec;

  modport master (
    output rd_req, rs1, rs2, iss_en, iss_rd, wb_en, wb_addr, wb_data,
    input  rdata1, rdata2, rvalid, rbusy1, rbusy2, busy_vec
  );

  modport slave (
    input  rd_req, rs1, rs2, iss_en, iss_rd, wb_en, wb_addr, wb_data,
    output rdata1, rdata2, rvalid, rbusy1, rbusy2, busy_vec
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register busy bits: issue sets, write-back clears, issue wins
module rf_scoreboard #(
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iss_en_i,
  input  logic [AW-1:0]    iss_rd_i,
  input  logic             wb_en_i,
  input  logic [AW-1:0]    wb_addr_i,
  output logic [NREGS-1:0] busy_q_o,
  output logic [NREGS-1:0] busy_d_o
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Issue is applied after the clear so a newer producer stays outstanding
  always_comb begin
    busy_d = busy_q;
    if (wb_en_i && wb_addr_i != '0) begin
      busy_d[wb_addr_i] = 1'b0;
    end
    if (iss_en_i && iss_rd_i != '0) begin
      busy_d[iss_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_q_o = busy_q;
  assign busy_d_o = busy_d;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - two-read/one-write register file with busy scoreboard
// RF_BYPASS_EN selects write-first reads of a same-cycle write-back (default read-first)
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int NREGS      = NREGS_DEFAULT,
  parameter int RESET_INIT = 0,
  localparam int AW        = $clog2(NREGS)
) (
  input logic                 clk,
  input logic                 reset,
  regfile_scoreboard_if.slave bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  rdata1_q, rdata1_d;
  logic [XLEN-1:0]  rdata2_q, rdata2_d;
  logic             rbusy1_q, rbusy2_q;
  logic             rvalid_q;
  logic [NREGS-1:0] busy_q, busy_d;

  rf_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .iss_en_i  (bus.iss_en),
    .iss_rd_i  (bus.iss_rd),
    .wb_en_i   (bus.wb_en),
    .wb_addr_i (bus.wb_addr),
    .busy_q_o  (busy_q),
    .busy_d_o  (busy_d)
  );

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    if (a == '0) begin
      return '0;
    end
`ifdef RF_BYPASS_EN
    if (bus.wb_en && bus.wb_addr == a) begin
      return bus.wb_data;
    end
`endif
    return regs_q[a];
  endfunction

  always_comb begin
    rdata1_d = read_port(bus.rs1);
    rdata2_d = read_port(bus.rs2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= XLEN'(init_value(i, RESET_INIT));
      end
    end else if (bus.wb_en && bus.wb_addr != '0) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // rbusy samples next-state busy so same-cycle issue/write-back are visible
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      rbusy1_q <= 1'b0;
      rbusy2_q <= 1'b0;
    end else begin
      rvalid_q <= bus.rd_req;
      if (bus.rd_req) begin
        rdata1_q <= rdata1_d;
        rdata2_q <= rdata2_d;
        rbusy1_q <= busy_d[bus.rs1];
        rbusy2_q <= busy_d[bus.rs2];
      end
    end
  end

  assign bus.rvalid   = rvalid_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.rdata2   = rdata2_q;
  assign bus.rbusy1   = rbusy1_q;
  assign bus.rbusy2   = rbusy2_q;
  assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed and random checks of regfile_scoreboard against a reference model
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  regfile_scoreboard_if #(.XLEN(64), .NREGS(32)) bus ();

  regfile_scoreboard #(.XLEN(64), .NREGS(32), .RESET_INIT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [63:0] m_regs [32];
  logic [31:0] m_busy;
  logic [63:0] e_rdata1, e_rdata2;
  logic        e_rvalid, e_rbusy1, e_rbusy2;

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 0) ? 64'd0 : 64'(i + 1);
    m_busy   = '0;
    e_rdata1 = '0;
    e_rdata2 = '0;
    e_rvalid = 1'b0;
    e_rbusy1 = 1'b0;
    e_rbusy2 = 1'b0;
  endtask

  function automatic logic [63:0] m_read(input int a);
    if (a == 0) return 64'd0;
    if (BYPASS && bus.wb_en && int'(bus.wb_addr) == a) return bus.wb_data;
    return m_regs[a];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".rvalid"},   64'(bus.rvalid),   64'(e_rvalid));
    check({tag, ".rdata1"},   bus.rdata1,        e_rdata1);
    check({tag, ".rdata2"},   bus.rdata2,        e_rdata2);
    check({tag, ".rbusy1"},   64'(bus.rbusy1),   64'(e_rbusy1));
    check({tag, ".rbusy2"},   64'(bus.rbusy2),   64'(e_rbusy2));
    check({tag, ".busy_vec"}, 64'(bus.busy_vec), 64'(m_busy));
  endtask

  // Advance one edge, apply the architectural rules to the model, compare everything
  task automatic tick(input string tag);
    logic [31:0] nb;
    @(posedge clk);
    #1;
    nb = m_busy;
    if (bus.wb_en && bus.wb_addr != 0) nb[bus.wb_addr] = 1'b0;
    if (bus.iss_en && bus.iss_rd != 0) nb[bus.iss_rd] = 1'b1;
    e_rvalid = bus.rd_req;
    if (bus.rd_req) begin
      e_rdata1 = m_read(int'(bus.rs1));
      e_rdata2 = m_read(int'(bus.rs2));
      e_rbusy1 = nb[bus.rs1];
      e_rbusy2 = nb[bus.rs2];
    end
    if (bus.wb_en && bus.wb_addr != 0) m_regs[bus.wb_addr] = bus.wb_data;
    m_busy = nb;
    check_all(tag);
  endtask

  task automatic idle();
    bus.rd_req = 0; bus.rs1 = 0; bus.rs2 = 0;
    bus.iss_en = 0; bus.iss_rd = 0;
    bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
  endtask

  initial begin
    logic [63:0] last1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) reset = 0;

    bus.rd_req = 1; bus.rs1 = 5; bus.rs2 = 31;
    tick("rd5_31");
    check("init_r5", bus.rdata1, 64'd6);
    check("init_r31", bus.rdata2, 64'd32);
    bus.rs1 = 0; bus.rs2 = 5;
    tick("rd0");
    check("r0_zero", bus.rdata1, 64'd0);

    idle(); bus.wb_en = 1; bus.wb_addr = 0; bus.wb_data = 64'hDEAD;
    tick("wb0");
    idle(); bus.rd_req = 1; bus.rs1 = 0;
    tick("rd0_after_wb0");
    check("r0_ignores_wb", bus.rdata1, 64'd0);
    idle(); bus.iss_en = 1; bus.iss_rd = 0;
    tick("iss0");
    check("busy0", 64'(bus.busy_vec[0]), 64'd0);

    idle(); bus.wb_en = 1; bus.wb_addr = 7; bus.wb_data = 64'h1234;
    bus.rd_req = 1; bus.rs1 = 7;
    tick("rd_wb_same");
    check("rd_wb_same_data", bus.rdata1, BYPASS ? 64'h1234 : 64'd8);
    idle(); bus.rd_req = 1; bus.rs1 = 7;
    tick("rd7_after");
    check("r7_written", bus.rdata1, 64'h1234);

    idle(); bus.iss_en = 1; bus.iss_rd = 3;
    tick("iss3");
    check("busy3_set", 64'(bus.busy_vec[3]), 64'd1);
    idle(); bus.rd_req = 1; bus.rs2 = 3;
    tick("rd3_busy");
    check("rbusy2_3", 64'(bus.rbusy2), 64'd1);
    idle(); bus.iss_en = 1; bus.iss_rd = 3; bus.wb_en = 1; bus.wb_addr = 3; bus.wb_data = 64'h33;
    tick("iss_wb3");
    check("busy3_issue_wins", 64'(bus.busy_vec[3]), 64'd1);
    idle(); bus.wb_en = 1; bus.wb_addr = 3; bus.wb_data = 64'h44;
    tick("wb3");
    check("busy3_clear", 64'(bus.busy_vec[3]), 64'd0);

    idle(); bus.iss_en = 1; bus.iss_rd = 9; bus.rd_req = 1; bus.rs1 = 5;
    bus.wb_en = 1; bus.wb_addr = 9; bus.wb_data = 64'h99;
    tick("iss9");
    #3 reset = 1;
    #1;
    model_reset();
    check("areset_busy", 64'(bus.busy_vec), 64'd0);
    check("areset_rvalid", 64'(bus.rvalid), 64'd0);
    check("areset_rdata1", bus.rdata1, 64'd0);
    idle();
    @(negedge clk) reset = 0;
    bus.rd_req = 1; bus.rs1 = 9; bus.rs2 = 7;
    tick("rd9_after_reset");
    check("r9_init", bus.rdata1, 64'd10);

    for (int n = 0; n < 300; n++) begin
      bus.rd_req  = $urandom_range(0, 1);
      bus.rs1     = 5'($urandom_range(0, 31));
      bus.rs2     = ($urandom_range(0, 3) == 0) ? bus.rs1 : 5'($urandom_range(0, 31));
      bus.iss_en  = ($urandom_range(0, 2) == 0);
      bus.iss_rd  = ($urandom_range(0, 1) == 0) ? bus.rs1 : 5'($urandom_range(0, 31));
      bus.wb_en   = ($urandom_range(0, 1) == 0);
      bus.wb_addr = ($urandom_range(0, 2) == 0) ? bus.rs2 : 5'($urandom_range(0, 31));
      bus.wb_data = {$urandom, $urandom};
      tick("rand");
    end

    idle();
    for (int i = 0; i < 4; i++) begin
      bus.rd_req = 1; bus.rs1 = 5'(i * 5 + 1); bus.rs2 = 5'(31 - i);
      bus.wb_en = 1; bus.wb_addr = 5'(i * 5 + 1); bus.wb_data = {$urandom, $urandom};
      tick("b2b");
      check("b2b_rvalid", 64'(bus.rvalid), 64'd1);
    end
    last1 = e_rdata1;
    idle();
    tick("drop");
    tick("hold");
    check("hold_rdata1", bus.rdata1, last1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
